// File: rtl/bpf_band_scheduler.sv
// -----------------------------------------------------------------------------
// bpf_band_scheduler
//
// Purpose:
//   Time-multiplexes one shared band-pass IIR engine across NUM_BANDS filter
//   bands. On each synchronized rising edge of the audio sample clock it
//   latches the left-channel sample. It then launches the engine once per
//   band and stores each band's low-passed magnitude into a packed power
//   vector for the spectrum visualizer.
//
// Parameters:
//   NUM_BANDS   bands sequenced per sample (1..8)
//   TIMEOUT     max WAIT cycles per band before the band is abandoned (1..255)
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   aud_clk      in   audio sample clock, asynchronous to clk
//   enable       in   1 = accept new samples
//   iAud_L       in   signed 16-bit left-channel sample
//   eng_start    out  single-cycle engine launch pulse
//   eng_band     out  band index for the engine, valid with eng_start
//   eng_sample   out  latched sample presented to the engine
//   eng_done     in   engine completion pulse
//   eng_mag      in   engine low-passed magnitude, valid with eng_done
//   power        out  packed band powers, band k at [11k+10:11k]
//   frame_valid  out  one-cycle pulse after all bands are updated
//   busy         out  FSM not idle
//   overrun      out  sticky: a sample edge arrived while busy
//   timeout_err  out  sticky: a band timed out waiting for eng_done
// -----------------------------------------------------------------------------
module bpf_band_scheduler #(
  parameter int NUM_BANDS = 6,
  parameter int TIMEOUT   = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     aud_clk,
  input  logic                     enable,
  input  logic [15:0]              iAud_L,
  output logic                     eng_start,
  output logic [2:0]               eng_band,
  output logic [15:0]              eng_sample,
  input  logic                     eng_done,
  input  logic [26:0]              eng_mag,
  output logic [11*NUM_BANDS-1:0]  power,
  output logic                     frame_valid,
  output logic                     busy,
  output logic                     overrun,
  output logic                     timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_sync1;
  logic        r_sync2;
  logic        r_sync_prev;
  logic [2:0]  r_band;
  logic [7:0]  r_wait_cnt;
  logic        r_eng_start;
  logic [2:0]  r_eng_band;
  logic [15:0] r_eng_sample;
  logic        r_frame_valid;
  logic        r_overrun;
  logic        r_timeout_err;

  logic        w_edge;
  logic        w_timeout;
  logic        w_advance;
  logic        w_last;
  logic [10:0] w_wr_data;
  logic        w_unused_mag;

  genvar gi;

  // Edge cycle: synchronized level is 1 and was 0 the cycle before.
  assign w_edge = r_sync2 & ~r_sync_prev;

  // The timeout fires on the TIMEOUT-th WAIT cycle; a done in the same cycle
  // takes priority so that a late-but-valid result is still stored.
  assign w_timeout = (r_state == S_WAIT) && !eng_done &&
                     ((r_wait_cnt + 8'd1) == 8'(TIMEOUT));
  assign w_advance = (r_state == S_WAIT) && (eng_done || w_timeout);
  assign w_last    = (r_band == 3'(NUM_BANDS - 1));
  assign w_wr_data = eng_done ? eng_mag[22:12] : 11'd0;

  // Only eng_mag[22:12] carries the displayed power.
  assign w_unused_mag = ^{eng_mag[26:23], eng_mag[11:0]};

  // Two-flop synchronizer plus a delayed copy for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_sync_prev <= 1'b0;
    end else begin
      r_sync1     <= aud_clk;
      r_sync2     <= r_sync1;
      r_sync_prev <= r_sync2;
    end
  end

  // Sequencer FSM with registered outputs. eng_start is raised on the
  // transition into LAUNCH so it is high exactly during the LAUNCH cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_band        <= 3'd0;
      r_wait_cnt    <= 8'd0;
      r_eng_start   <= 1'b0;
      r_eng_band    <= 3'd0;
      r_eng_sample  <= 16'd0;
      r_frame_valid <= 1'b0;
      r_overrun     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_eng_start   <= 1'b0;
      r_frame_valid <= 1'b0;

      // A sample arriving mid-frame is dropped; the frame carries on.
      if (w_edge && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_edge && enable) begin
            r_eng_sample <= iAud_L;
            r_band       <= 3'd0;
            r_eng_band   <= 3'd0;
            r_eng_start  <= 1'b1;
            r_state      <= S_LAUNCH;
          end
        end

        S_LAUNCH: begin
          r_wait_cnt <= 8'd0;
          r_state    <= S_WAIT;
        end

        S_WAIT: begin
          if (w_advance) begin
            if (!eng_done) begin
              r_timeout_err <= 1'b1;
            end
            if (w_last) begin
              r_frame_valid <= 1'b1;
              r_state       <= S_IDLE;
            end else begin
              r_band      <= r_band + 3'd1;
              r_eng_band  <= r_band + 3'd1;
              r_eng_start <= 1'b1;
              r_state     <= S_LAUNCH;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // One power register per band; only the slot of the active band is
  // written, every other slot holds.
  generate
    for (gi = 0; gi < NUM_BANDS; gi++) begin : g_slot
      logic [10:0] r_slot;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_slot <= 11'd0;
        end else if (w_advance && (r_band == 3'(gi))) begin
          r_slot <= w_wr_data;
        end
      end

      assign power[11*gi +: 11] = r_slot;
    end
  endgenerate

  assign eng_start   = r_eng_start;
  assign eng_band    = r_eng_band;
  assign eng_sample  = r_eng_sample;
  assign frame_valid = r_frame_valid;
  assign busy        = (r_state != S_IDLE);
  assign overrun     = r_overrun;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_bpf_band_scheduler.sv
// -----------------------------------------------------------------------------
// tb_bpf_band_scheduler
//
// Purpose:
//   Directed testbench for bpf_band_scheduler. A small engine model answers
//   each eng_start with eng_done after a programmable latency. A negedge
//   monitor records every launch (band, cycle) and every frame_valid pulse.
// -----------------------------------------------------------------------------
module tb_bpf_band_scheduler;

  localparam int NB = 6;
  localparam int TO = 255;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              aud_clk = 1'b0;
  logic              enable = 1'b0;
  logic [15:0]       iAud_L = 16'h0000;
  logic              eng_start;
  logic [2:0]        eng_band;
  logic [15:0]       eng_sample;
  logic              eng_done;
  logic [26:0]       eng_mag;
  logic [11*NB-1:0]  power;
  logic              frame_valid;
  logic              busy;
  logic              overrun;
  logic              timeout_err;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  bpf_band_scheduler #(.NUM_BANDS(NB), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .aud_clk     (aud_clk),
    .enable      (enable),
    .iAud_L      (iAud_L),
    .eng_start   (eng_start),
    .eng_band    (eng_band),
    .eng_sample  (eng_sample),
    .eng_done    (eng_done),
    .eng_mag     (eng_mag),
    .power       (power),
    .frame_valid (frame_valid),
    .busy        (busy),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- engine model ----------------
  int          m_lat  = 3;
  int          m_hang = -1;
  logic [10:0] m_base = 11'h123;
  logic        m_junk = 1'b0;
  int          cd     = 0;
  int          m_band = 0;
  logic        f_done = 1'b0;
  logic [26:0] f_mag  = 27'h0;

  function automatic logic [10:0] exp_slot(input int k, input logic [10:0] base);
    int prod;
    prod = int'(base) * (k + 1);
    return prod[10:0];
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      cd <= 0;
    end else if (eng_start) begin
      cd     <= m_lat;
      m_band <= int'(eng_band);
    end else if (cd > 0) begin
      cd <= cd - 1;
    end
  end

  assign eng_done = f_done | ((cd == 1) && (m_band != m_hang));
  assign eng_mag  = f_done ? f_mag :
                    {(m_junk ? 4'hF : 4'h0), exp_slot(m_band, m_base),
                     (m_junk ? 12'hABC : 12'h000)};

  // ---------------- monitor ----------------
  int st_band[$];
  int st_cyc[$];
  int fv_n   = 0;
  int fv_cyc = 0;
  int busy_n = 0;

  always @(negedge clk) begin
    if (eng_start) begin
      st_band.push_back(int'(eng_band));
      st_cyc.push_back(cyc);
    end
    if (frame_valid) begin
      fv_n   <= fv_n + 1;
      fv_cyc <= cyc;
    end
    if (busy) busy_n <= busy_n + 1;
  end

  // ---------------- helpers (stimulus / bounded waits) ----------------
  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    step(3);
    reset = 1'b1;
    step(3);
  endtask

  task automatic wait_fv(input int base, input int budget, input string nm);
    int i;
    i = 0;
    while (fv_n == base && i < budget) begin
      step();
      i++;
    end
    tests++;
    if (fv_n == base) begin
      fails++;
      $display("FAIL %s: frame_valid not seen within %0d cycles", nm, budget);
    end
  endtask

  task automatic wait_starts(input int target, input int budget, input string nm);
    int i;
    i = 0;
    while (st_band.size() < target && i < budget) begin
      step();
      i++;
    end
    tests++;
    if (st_band.size() < target) begin
      fails++;
      $display("FAIL %s: only %0d launches, needed %0d", nm, st_band.size(), target);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    step(2);
    tests++;
    if ({eng_start, eng_band, frame_valid, busy, overrun, timeout_err} !== 8'h00) begin
      fails++;
      $display("FAIL reset_ctrl: got %b expected 0", {eng_start, eng_band, frame_valid, busy, overrun, timeout_err});
    end
    tests++;
    if (power !== '0) begin fails++; $display("FAIL reset_power: got %h expected 0", power); end
    tests++;
    if (eng_sample !== 16'h0) begin fails++; $display("FAIL reset_sample: got %h expected 0", eng_sample); end
    reset  = 1'b1;
    enable = 1'b1;
    step(3);
  endtask

  task automatic test_frame();
    int b0, f0, rc, n;
    b0 = st_band.size(); f0 = fv_n;
    m_lat = 3; iAud_L = 16'h1234;
    aud_clk = 1'b1; rc = cyc;
    step(4);
    aud_clk = 1'b0;
    wait_fv(f0, 200, "frame_wait");
    step(2);
    n = st_band.size() - b0;
    tests++;
    if (n != NB) begin fails++; $display("FAIL frame_starts: got %0d expected %0d", n, NB); end
    if (n == NB) begin
      tests++;
      if (st_cyc[b0] - rc < 3 || st_cyc[b0] - rc > 4) begin
        fails++; $display("FAIL frame_first_latency: got %0d expected 3..4", st_cyc[b0] - rc);
      end
      for (int k = 0; k < NB; k++) begin
        tests++;
        if (st_band[b0+k] != k) begin fails++; $display("FAIL frame_band%0d: got %0d expected %0d", k, st_band[b0+k], k); end
        if (k > 0) begin
          tests++;
          if (st_cyc[b0+k] - st_cyc[b0+k-1] != 4) begin
            fails++; $display("FAIL frame_spacing%0d: got %0d expected 4", k, st_cyc[b0+k] - st_cyc[b0+k-1]);
          end
        end
      end
      tests++;
      if (fv_cyc - st_cyc[b0+NB-1] != 4) begin
        fails++; $display("FAIL frame_fv_latency: got %0d expected 4", fv_cyc - st_cyc[b0+NB-1]);
      end
    end
    for (int k = 0; k < NB; k++) begin
      tests++;
      if (power[11*k +: 11] !== exp_slot(k, 11'h123)) begin
        fails++; $display("FAIL frame_slot%0d: got %h expected %h", k, power[11*k +: 11], exp_slot(k, 11'h123));
      end
    end
    tests++;
    if (fv_n - f0 != 1) begin fails++; $display("FAIL frame_fv_count: got %0d expected 1", fv_n - f0); end
    tests++;
    if (eng_sample !== 16'h1234) begin fails++; $display("FAIL frame_sample: got %h expected 1234", eng_sample); end
    tests++;
    if ({busy, overrun, timeout_err} !== 3'b000) begin
      fails++; $display("FAIL frame_flags: got %b expected 000", {busy, overrun, timeout_err});
    end
  endtask

  task automatic test_timeout();
    int b0, f0, n;
    b0 = st_band.size(); f0 = fv_n;
    m_lat = 3; m_hang = 2;
    aud_clk = 1'b1;
    step(4);
    aud_clk = 1'b0;
    wait_fv(f0, 2000, "timeout_wait");
    step(2);
    m_hang = -1;
    n = st_band.size() - b0;
    tests++;
    if (n != NB) begin fails++; $display("FAIL timeout_starts: got %0d expected %0d", n, NB); end
    if (n == NB) begin
      tests++;
      if (st_cyc[b0+3] - st_cyc[b0+2] != TO + 1) begin
        fails++; $display("FAIL timeout_spacing: got %0d expected %0d", st_cyc[b0+3] - st_cyc[b0+2], TO + 1);
      end
      tests++;
      if (st_band[b0+5] != 5) begin fails++; $display("FAIL timeout_last_band: got %0d expected 5", st_band[b0+5]); end
    end
    for (int k = 0; k < NB; k++) begin
      tests++;
      if (power[11*k +: 11] !== ((k == 2) ? 11'h000 : exp_slot(k, 11'h123))) begin
        fails++; $display("FAIL timeout_slot%0d: got %h", k, power[11*k +: 11]);
      end
    end
    tests++;
    if (timeout_err !== 1'b1) begin fails++; $display("FAIL timeout_flag: got %b expected 1", timeout_err); end
    tests++;
    if (fv_n - f0 != 1) begin fails++; $display("FAIL timeout_fv: got %0d expected 1", fv_n - f0); end
  endtask

  task automatic test_overrun();
    int b0, f0, n;
    apply_reset();
    b0 = st_band.size(); f0 = fv_n;
    m_lat = 10; iAud_L = 16'h1234;
    aud_clk = 1'b1;
    step(4);
    aud_clk = 1'b0;
    wait_starts(b0 + 2, 100, "overrun_band1");
    iAud_L  = 16'h5555;
    aud_clk = 1'b1;
    step(4);
    aud_clk = 1'b0;
    wait_fv(f0, 300, "overrun_wait");
    step(20);
    n = st_band.size() - b0;
    tests++;
    if (overrun !== 1'b1) begin fails++; $display("FAIL overrun_flag: got %b expected 1", overrun); end
    tests++;
    if (n != NB) begin fails++; $display("FAIL overrun_starts: got %0d expected %0d", n, NB); end
    tests++;
    if (eng_sample !== 16'h1234) begin fails++; $display("FAIL overrun_sample: got %h expected 1234", eng_sample); end
    tests++;
    if (fv_n - f0 != 1) begin fails++; $display("FAIL overrun_fv: got %0d expected 1", fv_n - f0); end
    tests++;
    if (timeout_err !== 1'b0) begin fails++; $display("FAIL overrun_timeout_flag: got %b expected 0", timeout_err); end
  endtask

  task automatic test_enable();
    int b0, f0, bz0, n;
    logic [11*NB-1:0] p0;
    m_lat = 3;
    enable = 1'b0;
    p0 = power; b0 = st_band.size(); bz0 = busy_n;
    for (int e = 0; e < 3; e++) begin
      aud_clk = 1'b1;
      step(4);
      aud_clk = 1'b0;
      step(4);
    end
    step(5);
    tests++;
    if (st_band.size() != b0) begin fails++; $display("FAIL enable_off_starts: got %0d expected 0", st_band.size() - b0); end
    tests++;
    if (busy_n != bz0) begin fails++; $display("FAIL enable_off_busy: got %0d busy cycles expected 0", busy_n - bz0); end
    tests++;
    if (power !== p0) begin fails++; $display("FAIL enable_off_power: got %h expected %h", power, p0); end

    // enable dropped after the first launch: the frame must still finish
    enable = 1'b1; m_base = 11'h051; m_junk = 1'b1;
    b0 = st_band.size(); f0 = fv_n;
    aud_clk = 1'b1;
    wait_starts(b0 + 1, 20, "enable_mid_first");
    enable = 1'b0;
    step(2);
    aud_clk = 1'b0;
    wait_fv(f0, 200, "enable_mid_wait");
    step(2);
    n = st_band.size() - b0;
    tests++;
    if (n != NB) begin fails++; $display("FAIL enable_mid_starts: got %0d expected %0d", n, NB); end
    for (int k = 0; k < NB; k++) begin
      tests++;
      if (power[11*k +: 11] !== exp_slot(k, 11'h051)) begin
        fails++; $display("FAIL enable_mid_slot%0d: got %h expected %h", k, power[11*k +: 11], exp_slot(k, 11'h051));
      end
    end
    aud_clk = 1'b1;
    step(4);
    aud_clk = 1'b0;
    step(10);
    tests++;
    if (st_band.size() - b0 != NB) begin
      fails++; $display("FAIL enable_after_starts: got %0d expected %0d", st_band.size() - b0, NB);
    end
    m_base = 11'h123; m_junk = 1'b0; enable = 1'b1;
  endtask

  task automatic test_async_reset();
    int b0, f0, n;
    m_lat = 3; b0 = st_band.size();
    aud_clk = 1'b1;
    step(4);
    aud_clk = 1'b0;
    wait_starts(b0 + 5, 100, "areset_band4");
    step(1);
    #2;
    reset = 1'b0;
    #1;
    tests++;
    if ({eng_start, eng_band, frame_valid, busy, overrun, timeout_err} !== 8'h00) begin
      fails++;
      $display("FAIL areset_ctrl: got %b expected 0", {eng_start, eng_band, frame_valid, busy, overrun, timeout_err});
    end
    tests++;
    if (power !== '0) begin fails++; $display("FAIL areset_power: got %h expected 0", power); end
    tests++;
    if (eng_sample !== 16'h0) begin fails++; $display("FAIL areset_sample: got %h expected 0", eng_sample); end
    step(2);
    reset = 1'b1;
    step(3);
    b0 = st_band.size(); f0 = fv_n;
    iAud_L = 16'hBEEF;
    aud_clk = 1'b1;
    step(4);
    aud_clk = 1'b0;
    wait_fv(f0, 200, "areset_restart");
    step(2);
    n = st_band.size() - b0;
    tests++;
    if (n != NB) begin fails++; $display("FAIL areset_starts: got %0d expected %0d", n, NB); end
    if (n > 0) begin
      tests++;
      if (st_band[b0] != 0) begin fails++; $display("FAIL areset_first_band: got %0d expected 0", st_band[b0]); end
    end
    tests++;
    if (eng_sample !== 16'hBEEF) begin fails++; $display("FAIL areset_sample2: got %h expected beef", eng_sample); end
    tests++;
    if (power[11*4 +: 11] !== exp_slot(4, 11'h123)) begin
      fails++; $display("FAIL areset_slot4: got %h expected %h", power[11*4 +: 11], exp_slot(4, 11'h123));
    end
  endtask

  task automatic test_done_ignored();
    int b0, f0, n;
    apply_reset();
    b0 = st_band.size();
    f_mag  = {4'h0, 11'h7FF, 12'h000};
    f_done = 1'b1;
    step(1);
    f_done = 1'b0;
    step(2);
    tests++;
    if (power !== '0) begin fails++; $display("FAIL idle_done_power: got %h expected 0", power); end
    tests++;
    if (busy !== 1'b0 || st_band.size() != b0) begin
      fails++; $display("FAIL idle_done_busy: got busy=%b launches=%0d expected 0", busy, st_band.size() - b0);
    end

    // done injected in LAUNCH, then engine answering exactly at the timeout
    m_lat = TO; f0 = fv_n;
    aud_clk = 1'b1;
    wait_starts(b0 + 1, 20, "launch_done_start");
    f_done = 1'b1;
    step(1);
    f_done = 1'b0;
    step(2);
    aud_clk = 1'b0;
    wait_fv(f0, 2500, "simul_wait");
    step(2);
    n = st_band.size() - b0;
    tests++;
    if (n != NB) begin fails++; $display("FAIL simul_starts: got %0d expected %0d", n, NB); end
    if (n == NB) begin
      tests++;
      if (st_cyc[b0+1] - st_cyc[b0] != TO + 1) begin
        fails++; $display("FAIL launch_done_spacing: got %0d expected %0d", st_cyc[b0+1] - st_cyc[b0], TO + 1);
      end
    end
    for (int k = 0; k < NB; k++) begin
      tests++;
      if (power[11*k +: 11] !== exp_slot(k, 11'h123)) begin
        fails++; $display("FAIL simul_slot%0d: got %h expected %h", k, power[11*k +: 11], exp_slot(k, 11'h123));
      end
    end
    tests++;
    if (timeout_err !== 1'b0) begin fails++; $display("FAIL simul_timeout_flag: got %b expected 0", timeout_err); end
    tests++;
    if (fv_n - f0 != 1) begin fails++; $display("FAIL simul_fv: got %0d expected 1", fv_n - f0); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_timeout();
    test_overrun();
    test_enable();
    test_async_reset();
    test_done_ignored();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
